// File: rtl/rx_spi_fifo_if.sv
// rx_spi_fifo_if: capture strobe, host SPI pins and status bundle of rx_spi_fifo.
//   master : capture source / host side (drives strobe, channel data, SPI pins)
//   slave  : rx_spi_fifo (drives MISO, packet-ready, overrun, fill, debug)
interface rx_spi_fifo_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 512
);
  localparam int unsigned FW = $clog2(DEPTH) + 1;

  logic                    rxstrobe;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [2:0]              channels;
  logic                    enable;
  logic                    clear_status;
  logic                    spi_clk;
  logic                    spi_cs_n;
  logic                    spi_output;
  logic                    have_pkt_rdy;
  logic                    rx_overrun;
  logic [FW-1:0]           fill_level;
  logic [15:0]             debug_bus;

  modport master (
    output rxstrobe, ch_data, channels, enable, clear_status, spi_clk, spi_cs_n,
    input  spi_output, have_pkt_rdy, rx_overrun, fill_level, debug_bus
  );

  modport slave (
    input  rxstrobe, ch_data, channels, enable, clear_status, spi_clk, spi_cs_n,
    output spi_output, have_pkt_rdy, rx_overrun, fill_level, debug_bus
  );
endinterface

// File: rtl/rx_spi_fifo.sv
// rx_spi_fifo: captures up to NUM_CH interleaved receive channels per rxstrobe
// into a circular sample FIFO and streams it out through an oversampled
// SPI mode-0 slave (MSB first), all in the rx_clk domain.
//   rx_clk        : sole clock, rising edge
//   reset_n       : asynchronous active-low reset
//   bus (slave)   : rxstrobe/ch_data/channels/enable/clear_status in,
//                   spi_clk/spi_cs_n in (asynchronous pins), spi_output out,
//                   have_pkt_rdy/rx_overrun/fill_level/debug_bus status out
module rx_spi_fifo #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned PKT_WORDS = 256
) (
  input logic           rx_clk,
  input logic           reset_n,
  rx_spi_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [FW-1:0] DEPTH_FW = FW'(DEPTH);
  localparam logic [FW-1:0] PKT_FW   = FW'(PKT_WORDS);
  localparam logic [2:0]    NCH      = 3'(NUM_CH);
  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);

  typedef enum logic {CAP_IDLE, CAP_WRITE} cap_state_e;

  cap_state_e              cap_q;
  logic [NUM_CH*WIDTH-1:0] set_q;
  logic [2:0]              rem_q;
  logic                    ovr_q;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]           fill_q, fill_d;
  logic                    have_q;

  logic                    sclk_s1_q, sclk_s2_q, sclk_d_q;
  logic                    cs_s1_q, cs_s2_q, cs_d_q;
  logic [WIDTH-1:0]        sh_q;
  logic [CW-1:0]           bit_q;

  logic                    strobe_v, fits, drop, push, pop, load;
  logic                    cs_fall, cs_rise, cs_low, sclk_rise, sclk_fall, word_done;
  logic [2:0]              n_req;
  logic [FW-1:0]           free_w;
  logic [WIDTH-1:0]        load_word;

  always_comb begin
    strobe_v  = bus.rxstrobe & bus.enable;
    n_req     = (bus.channels == 3'd0 || bus.channels > NCH) ? NCH : bus.channels;
    free_w    = DEPTH_FW - fill_q;
    fits      = free_w >= FW'(n_req);
    // a set is either written whole or dropped whole, keeping channel alignment
    drop      = strobe_v & ((cap_q == CAP_WRITE) | ~fits);
    push      = (cap_q == CAP_WRITE);
    cs_fall   = cs_d_q & ~cs_s2_q;
    cs_rise   = ~cs_d_q & cs_s2_q;
    cs_low    = ~cs_d_q & ~cs_s2_q;
    sclk_rise = sclk_s2_q & ~sclk_d_q;
    sclk_fall = ~sclk_s2_q & sclk_d_q;
    word_done = (bit_q == WIDTH_CW);
    // the falling edge after the last sampled bit loads the next word instead of shifting
    load      = cs_fall | (cs_low & sclk_fall & word_done);
    pop       = load & (fill_q != '0);
    load_word = pop ? mem[rd_ptr_q] : '0;
    fill_d    = fill_q + FW'(push) - FW'(pop);
  end

  // capture FSM; the latched set is shifted down so channel 0 is always at the bottom
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= CAP_IDLE;
      set_q <= '0;
      rem_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      case (cap_q)
        CAP_IDLE: begin
          if (strobe_v && fits) begin
            set_q <= bus.ch_data;
            rem_q <= n_req;
            cap_q <= CAP_WRITE;
          end
        end
        CAP_WRITE: begin
          set_q <= set_q >> WIDTH;
          rem_q <= rem_q - 3'd1;
          if (rem_q == 3'd1) cap_q <= CAP_IDLE;
        end
      endcase
      if (drop)                  ovr_q <= 1'b1;
      else if (bus.clear_status) ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (push) mem[wr_ptr_q] <= set_q[WIDTH-1:0];
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      have_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
      have_q <= (fill_q >= PKT_FW);
    end
  end

  // SPI slave: 2-flop synchronisers plus one edge-detect stage per pin
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d_q  <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d_q    <= 1'b1;
      sh_q      <= '0;
      bit_q     <= '0;
    end else begin
      sclk_s1_q <= bus.spi_clk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d_q  <= sclk_s2_q;
      cs_s1_q   <= bus.spi_cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_d_q    <= cs_s2_q;
      if (cs_rise) begin
        sh_q  <= '0;
        bit_q <= '0;
      end else if (load) begin
        sh_q  <= load_word;
        bit_q <= '0;
      end else if (cs_low) begin
        if (sclk_fall)                    sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
        else if (sclk_rise && !word_done) bit_q <= bit_q + CW'(1);
      end
    end
  end

  assign bus.spi_output   = sh_q[WIDTH-1];
  assign bus.have_pkt_rdy = have_q;
  assign bus.rx_overrun   = ovr_q;
  assign bus.fill_level   = fill_q;
  assign bus.debug_bus    = {have_q, ovr_q, ~cs_d_q, (cap_q == CAP_WRITE), 12'(fill_q)};
endmodule

// File: tb/tb_rx_spi_fifo.sv
module tb_rx_spi_fifo;
  localparam int W     = 16;
  localparam int NCH   = 4;
  localparam int DEPTH = 64;
  localparam int PKT   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_spi_fifo_if #(.WIDTH(W), .NUM_CH(NCH), .DEPTH(DEPTH)) bus ();

  rx_spi_fifo #(.WIDTH(W), .NUM_CH(NCH), .DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
    .rx_clk (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int fails  = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: words accepted but not yet read, sticky flag, write-busy window
  logic [15:0] mq[$];
  bit          m_ovr = 1'b0;
  longint      busy_until = -1;
  logic [15:0] exp_word = '0;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_strobe(input logic [63:0] data, input logic [2:0] chans, input bit en, input bit clr);
    int n;
    bit dropped;
    n = (chans == 3'd0 || int'(chans) > NCH) ? NCH : int'(chans);
    dropped = 1'b0;
    @(posedge clk); #1;
    bus.ch_data = data; bus.channels = chans; bus.enable = en;
    bus.rxstrobe = 1'b1; bus.clear_status = clr;
    if (en) begin
      if (cyc <= busy_until || (DEPTH - mq.size()) < n) dropped = 1'b1;
      else begin
        for (int i = 0; i < n; i++) mq.push_back(data[i*16 +: 16]);
        busy_until = cyc + n;
      end
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(posedge clk); #1;
    bus.rxstrobe = 1'b0; bus.clear_status = 1'b0;
  endtask

  task automatic model_load();
    if (mq.size() > 0) exp_word = mq.pop_front();
    else exp_word = '0;
  endtask

  task automatic spi_begin();
    @(posedge clk); #1;
    bus.spi_cs_n = 1'b0;
    idle(4);
    model_load();
  endtask

  task automatic spi_end();
    bus.spi_cs_n = 1'b1;
    idle(4);
  endtask

  task automatic read_bits(input int nb, output logic [15:0] v);
    v = '0;
    for (int b = 0; b < nb; b++) begin
      v = {v[14:0], bus.spi_output};
      bus.spi_clk = 1'b1;
      idle(4);
      bus.spi_clk = 1'b0;
      idle(4);
    end
  endtask

  task automatic read_word(output logic [15:0] v, output logic [15:0] e);
    e = exp_word;
    read_bits(16, v);
    model_load();
  endtask

  task automatic test_reset();
    bus.rxstrobe = 0; bus.ch_data = '0; bus.channels = 3'd4; bus.enable = 1;
    bus.clear_status = 0; bus.spi_clk = 0; bus.spi_cs_n = 1;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    checks++; if (bus.fill_level !== 7'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", bus.fill_level); end
    checks++; if (bus.have_pkt_rdy !== 1'b0) begin fails++; $display("FAIL reset_have: got %b want 0", bus.have_pkt_rdy); end
    checks++; if (bus.rx_overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", bus.rx_overrun); end
    checks++; if (bus.spi_output !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", bus.spi_output); end
    checks++; if (bus.debug_bus !== 16'h0000) begin fails++; $display("FAIL reset_debug: got %h want 0000", bus.debug_bus); end
  endtask

  task automatic test_basic();
    logic [15:0] v, e;
    logic [63:0] d;
    for (int i = 0; i < PKT/2; i++) begin
      if (i == PKT/2 - 1) begin
        checks++; if (bus.have_pkt_rdy !== 1'b0) begin fails++; $display("FAIL basic_have_early: got %b want 0", bus.have_pkt_rdy); end
        checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL basic_fill_early: got %0d want %0d", bus.fill_level, mq.size()); end
      end
      d = {16'($urandom), 16'($urandom), 16'h8000 | 16'(i), 16'(i)};
      do_strobe(d, 3'd2, 1'b1, 1'b0);
      idle(6);
    end
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL basic_fill: got %0d want %0d", bus.fill_level, mq.size()); end
    checks++; if (bus.have_pkt_rdy !== (mq.size() >= PKT)) begin fails++; $display("FAIL basic_have: got %b want %b", bus.have_pkt_rdy, mq.size() >= PKT); end
    checks++; if (bus.debug_bus !== {(mq.size() >= PKT), m_ovr, 2'b00, 12'(mq.size())}) begin
      fails++; $display("FAIL basic_debug: got %h want %h", bus.debug_bus, {(mq.size() >= PKT), m_ovr, 2'b00, 12'(mq.size())}); end
    spi_begin();
    checks++; if (bus.have_pkt_rdy !== (mq.size() >= PKT)) begin fails++; $display("FAIL basic_have_drop: got %b want %b", bus.have_pkt_rdy, mq.size() >= PKT); end
    for (int w = 0; w < PKT; w++) begin
      read_word(v, e);
      checks++; if (v !== e) begin fails++; $display("FAIL basic_word%0d: got %h want %h", w, v, e); end
    end
    spi_end();
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL basic_fill_end: got %0d want %0d", bus.fill_level, mq.size()); end
    checks++; if (bus.spi_output !== 1'b0) begin fails++; $display("FAIL basic_miso_idle: got %b want 0", bus.spi_output); end
  endtask

  task automatic test_full();
    logic [15:0] v, e;
    int n;
    for (int i = 0; i < DEPTH - 1; i++) begin
      do_strobe({$urandom, $urandom}, 3'd1, 1'b1, 1'b0);
      idle(1);
    end
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL full_fill: got %0d want %0d", bus.fill_level, mq.size()); end
    do_strobe({$urandom, $urandom}, 3'd2, 1'b1, 1'b0);
    idle(3);
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL full_drop_fill: got %0d want %0d", bus.fill_level, mq.size()); end
    checks++; if (bus.rx_overrun !== m_ovr) begin fails++; $display("FAIL full_ovr: got %b want %b", bus.rx_overrun, m_ovr); end
    do_strobe({$urandom, $urandom}, 3'd2, 1'b1, 1'b1);
    idle(1);
    checks++; if (bus.rx_overrun !== m_ovr) begin fails++; $display("FAIL full_set_wins: got %b want %b", bus.rx_overrun, m_ovr); end
    do_strobe({$urandom, $urandom}, 3'd1, 1'b0, 1'b1);
    idle(1);
    checks++; if (bus.rx_overrun !== m_ovr) begin fails++; $display("FAIL full_clear: got %b want %b", bus.rx_overrun, m_ovr); end
    do_strobe({$urandom, $urandom}, 3'd1, 1'b0, 1'b0);
    idle(3);
    checks++; if (bus.fill_level !== 7'(mq.size()) || bus.rx_overrun !== m_ovr) begin
      fails++; $display("FAIL full_disabled: got fill %0d ovr %b want fill %0d ovr %b", bus.fill_level, bus.rx_overrun, mq.size(), m_ovr); end
    do_strobe({$urandom, $urandom}, 3'd1, 1'b1, 1'b0);
    idle(3);
    checks++; if (bus.fill_level !== 7'(mq.size()) || bus.have_pkt_rdy !== (mq.size() >= PKT)) begin
      fails++; $display("FAIL full_to_depth: got fill %0d have %b want fill %0d", bus.fill_level, bus.have_pkt_rdy, mq.size()); end
    do_strobe({$urandom, $urandom}, 3'd1, 1'b1, 1'b0);
    idle(1);
    checks++; if (bus.rx_overrun !== m_ovr || bus.fill_level !== 7'(mq.size())) begin
      fails++; $display("FAIL full_at_depth_drop: got ovr %b fill %0d want ovr %b fill %0d", bus.rx_overrun, bus.fill_level, m_ovr, mq.size()); end
    do_strobe('0, 3'd1, 1'b0, 1'b1);
    n = mq.size();
    spi_begin();
    for (int w = 0; w < n; w++) begin
      read_word(v, e);
      checks++; if (v !== e) begin fails++; $display("FAIL full_word%0d: got %h want %h", w, v, e); end
    end
    spi_end();
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL full_drained: got %0d want %0d", bus.fill_level, mq.size()); end
  endtask

  task automatic test_channels();
    logic [15:0] v, e;
    int n;
    for (int k = 0; k < 6; k++) begin
      do_strobe({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
      idle(5);
      checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL chan_fill%0d: got %0d want %0d", k, bus.fill_level, mq.size()); end
    end
    n = mq.size();
    spi_begin();
    for (int w = 0; w < n; w++) begin
      read_word(v, e);
      checks++; if (v !== e) begin fails++; $display("FAIL chan_word%0d: got %h want %h", w, v, e); end
    end
    spi_end();
  endtask

  task automatic test_write_strobe();
    logic [15:0] v, e;
    do_strobe({$urandom, $urandom}, 3'd4, 1'b1, 1'b0);
    checks++; if (bus.debug_bus[12] !== (cyc <= busy_until)) begin fails++; $display("FAIL ws_busy: got %b want %b", bus.debug_bus[12], cyc <= busy_until); end
    do_strobe({$urandom, $urandom}, 3'd4, 1'b1, 1'b0);
    idle(4);
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL ws_fill: got %0d want %0d", bus.fill_level, mq.size()); end
    checks++; if (bus.rx_overrun !== m_ovr) begin fails++; $display("FAIL ws_ovr: got %b want %b", bus.rx_overrun, m_ovr); end
    do_strobe('0, 3'd1, 1'b0, 1'b1);
    spi_begin();
    for (int w = 0; w < 4; w++) begin
      read_word(v, e);
      checks++; if (v !== e) begin fails++; $display("FAIL ws_word%0d: got %h want %h", w, v, e); end
    end
    spi_end();
  endtask

  task automatic test_empty();
    logic [15:0] v, e;
    spi_begin();
    for (int w = 0; w < 3; w++) begin
      read_word(v, e);
      checks++; if (v !== e) begin fails++; $display("FAIL empty_word%0d: got %h want %h", w, v, e); end
    end
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL empty_fill: got %0d want %0d", bus.fill_level, mq.size()); end
    fork
      read_word(v, e);
      begin idle(30); do_strobe({$urandom, $urandom}, 3'd1, 1'b1, 1'b0); end
    join
    checks++; if (v !== e) begin fails++; $display("FAIL empty_midword: got %h want %h", v, e); end
    read_word(v, e);
    checks++; if (v !== e) begin fails++; $display("FAIL empty_pushed: got %h want %h", v, e); end
    spi_end();
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL empty_fill_end: got %0d want %0d", bus.fill_level, mq.size()); end
  endtask

  task automatic test_concurrent();
    logic [15:0] v, e;
    int fmax, total;
    bit done;
    fmax = 0; done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_strobe({$urandom, $urandom}, 3'd4, 1'b1, 1'b0);
      idle(4);
    end
    total = 12 + 20 * 4;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          do_strobe({$urandom, $urandom}, 3'd4, 1'b1, 1'b0);
          idle($urandom_range(478, 538));
        end
      end
      begin
        spi_begin();
        for (int w = 0; w < total; w++) begin
          read_word(v, e);
          checks++; if (v !== e) begin fails++; $display("FAIL conc_word%0d: got %h want %h", w, v, e); end
        end
        spi_end();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (int'(bus.fill_level) > fmax) fmax = int'(bus.fill_level);
        end
      end
    join
    checks++; if (bus.rx_overrun !== m_ovr) begin fails++; $display("FAIL conc_ovr: got %b want %b", bus.rx_overrun, m_ovr); end
    checks++; if (fmax > 24) begin fails++; $display("FAIL conc_bound: got max fill %0d want <= 24", fmax); end
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL conc_fill_end: got %0d want %0d", bus.fill_level, mq.size()); end
  endtask

  task automatic test_abort_reset();
    logic [15:0] v, e;
    do_strobe({$urandom, $urandom}, 3'd2, 1'b1, 1'b0);
    idle(4);
    spi_begin();
    read_bits(5, v);
    checks++; if (v[4:0] !== exp_word[15:11]) begin fails++; $display("FAIL abort_bits: got %h want %h", v[4:0], exp_word[15:11]); end
    spi_end();
    checks++; if (bus.spi_output !== 1'b0) begin fails++; $display("FAIL abort_miso: got %b want 0", bus.spi_output); end
    spi_begin();
    read_word(v, e);
    checks++; if (v !== e) begin fails++; $display("FAIL abort_next: got %h want %h", v, e); end
    spi_end();
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL abort_fill: got %0d want %0d", bus.fill_level, mq.size()); end
    // park a word with MSB set in the shifter, set the sticky flag, then reset mid-write
    do_strobe({$urandom, $urandom} | 64'h8000_8000_8000_8000, 3'd4, 1'b1, 1'b0);
    do_strobe({$urandom, $urandom}, 3'd4, 1'b1, 1'b0);
    idle(4);
    spi_begin();
    checks++; if (bus.spi_output !== exp_word[15]) begin fails++; $display("FAIL rst_pre_miso: got %b want %b", bus.spi_output, exp_word[15]); end
    do_strobe({$urandom, $urandom}, 3'd4, 1'b1, 1'b0);
    rst_n = 1'b0;
    mq.delete(); m_ovr = 1'b0; busy_until = -1;
    #1;
    checks++; if (bus.spi_output !== 1'b0 || bus.fill_level !== 7'd0 || bus.have_pkt_rdy !== 1'b0 ||
                  bus.rx_overrun !== 1'b0 || bus.debug_bus !== 16'h0000) begin
      fails++; $display("FAIL rst_outputs: got miso %b fill %0d have %b ovr %b dbg %h want all 0",
                        bus.spi_output, bus.fill_level, bus.have_pkt_rdy, bus.rx_overrun, bus.debug_bus); end
    bus.spi_cs_n = 1'b1; bus.spi_clk = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    checks++; if (bus.fill_level !== 7'(mq.size())) begin fails++; $display("FAIL rst_fill_after: got %0d want %0d", bus.fill_level, mq.size()); end
    checks++; if (bus.spi_output !== 1'b0) begin fails++; $display("FAIL rst_miso_after: got %b want 0", bus.spi_output); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_channels();
    test_write_strobe();
    test_empty();
    test_concurrent();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
